// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesting masters, the arbiter and one shared slave.
// Latency: none (wires only).
// Backpressure: none; masters hold a request until their own res_valid pulse.
// Modport slave is the arbiter side; modport master is the environment side
// (both masters plus the shared slave's registered response).

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`define MEM_CODE_INVALID 2'd0
`define MEM_CODE_READ 2'd1
`define MEM_CODE_WRITE 2'd2
`define MEM_CODE_MISALIGNED 2'd3
`endif

interface mem_arbiter_if;
  logic [`ADDR_W-1:0]      i_m0_req_addr;
  logic [`MEM_COUNT_W-1:0] i_m0_req_count;
  logic                    o_m0_res_valid;
  logic [`WORD_W-1:0]      o_m0_res_rd_data;
  logic [`MEM_CODE_W-1:0]  o_m0_res_code;

  logic [`ADDR_W-1:0]      i_m1_req_addr;
  logic [`MEM_COUNT_W-1:0] i_m1_req_count;
  logic                    o_m1_res_valid;
  logic [`WORD_W-1:0]      o_m1_res_rd_data;
  logic [`MEM_CODE_W-1:0]  o_m1_res_code;

  logic [`ADDR_W-1:0]      o_s_req_addr;
  logic [`MEM_COUNT_W-1:0] o_s_req_count;
  logic [`WORD_W-1:0]      i_s_res_rd_data;
  logic [`MEM_CODE_W-1:0]  i_s_res_code;

  logic                    o_busy;

  modport slave (
    input  i_m0_req_addr, i_m0_req_count, i_m1_req_addr, i_m1_req_count,
           i_s_res_rd_data, i_s_res_code,
    output o_m0_res_valid, o_m0_res_rd_data, o_m0_res_code,
           o_m1_res_valid, o_m1_res_rd_data, o_m1_res_code,
           o_s_req_addr, o_s_req_count, o_busy
  );

  modport master (
    output i_m0_req_addr, i_m0_req_count, i_m1_req_addr, i_m1_req_count,
           i_s_res_rd_data, i_s_res_code,
    input  o_m0_res_valid, o_m0_res_rd_data, o_m0_res_code,
           o_m1_res_valid, o_m1_res_rd_data, o_m1_res_code,
           o_s_req_addr, o_s_req_count, o_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master to one-slave memory arbiter, one transaction in flight at a time.
// Latency: response pulse SLAVE_LATENCY+1 cycles after the IDLE grant cycle.
// Backpressure: none; a master holds its request until its res_valid pulse.
// Ports: clk, aresetn (async active-low), bus (mem_arbiter_if.slave).
// Optional macro MEM_ARB_ROUND_ROBIN_EN: on a tie, grant the master not served
// last; without it master 1 (data) always wins a tie.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`define MEM_CODE_INVALID 2'd0
`define MEM_CODE_READ 2'd1
`define MEM_CODE_WRITE 2'd2
`define MEM_CODE_MISALIGNED 2'd3
`endif

module mem_arbiter #(
  parameter int SLAVE_LATENCY = 1
) (
  input logic           clk,
  input logic           aresetn,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] LAT_LOAD = 2'(SLAVE_LATENCY - 1);

  state_t                  state, state_nxt;
  logic [1:0]              cnt, cnt_nxt;
  logic                    owner, owner_nxt;
  logic                    r_last, r_last_nxt;
  logic [`ADDR_W-1:0]      addr_q, addr_nxt;
  logic [`MEM_COUNT_W-1:0] count_q, count_nxt;

  logic req0, req1, win;

  assign req0 = (bus.i_m0_req_count != `MEM_COUNT_NONE);
  assign req1 = (bus.i_m1_req_count != `MEM_COUNT_NONE);

  // A lone requester always wins; only a tie depends on the policy.
`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign win = (req0 && req1) ? ~r_last : req1;
`else
  assign win = req1;
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      owner   <= 1'b0;
      r_last  <= 1'b1;
      addr_q  <= '0;
      count_q <= `MEM_COUNT_NONE;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      owner   <= owner_nxt;
      r_last  <= r_last_nxt;
      addr_q  <= addr_nxt;
      count_q <= count_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    owner_nxt  = owner;
    r_last_nxt = r_last;
    addr_nxt   = addr_q;
    count_nxt  = count_q;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_nxt  = win;
          r_last_nxt = win;
          addr_nxt   = win ? bus.i_m1_req_addr  : bus.i_m0_req_addr;
          count_nxt  = win ? bus.i_m1_req_count : bus.i_m0_req_count;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = LAT_LOAD;
        state_nxt = (SLAVE_LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        // Counter hits zero on the same edge that enters RESP.
        cnt_nxt = cnt - 2'd1;
        if (cnt == 2'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The latched address doubles as the slave address so it holds after ISSUE.
  assign bus.o_s_req_addr  = addr_q;
  assign bus.o_s_req_count = (state == ISSUE) ? count_q : `MEM_COUNT_NONE;
  assign bus.o_busy        = (state != IDLE);

  always_comb begin
    bus.o_m0_res_valid   = 1'b0;
    bus.o_m0_res_rd_data = '0;
    bus.o_m0_res_code    = `MEM_CODE_INVALID;
    bus.o_m1_res_valid   = 1'b0;
    bus.o_m1_res_rd_data = '0;
    bus.o_m1_res_code    = `MEM_CODE_INVALID;
    if (state == RESP) begin
      if (owner) begin
        bus.o_m1_res_valid   = 1'b1;
        bus.o_m1_res_rd_data = bus.i_s_res_rd_data;
        bus.o_m1_res_code    = bus.i_s_res_code;
      end else begin
        bus.o_m0_res_valid   = 1'b1;
        bus.o_m0_res_rd_data = bus.i_s_res_rd_data;
        bus.o_m0_res_code    = bus.i_s_res_code;
      end
    end
  end

endmodule
